// File: rtl/net_pkg.sv
// rtl/net_pkg.sv - shared fp32 constants, sequencer state encoding and sizing helper
package net_pkg;

    localparam logic [31:0] FP_ZERO = 32'h00000000;
    localparam logic [31:0] FP_ONE  = 32'h3f800000;

    typedef enum logic [2:0] {
        IDLE,
        BRD,
        BLD,
        WRD,
        MAC,
        ACT,
        DONE
    } state_t;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wgt_addr_gen.sv
// rtl/wgt_addr_gen.sv - per-neuron base and input-index counters driving the registered weight address
module wgt_addr_gen #(
    parameter int NI     = 2,
    parameter int AW     = 8,
    parameter int STRIDE = 3,
    parameter int IW     = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step_i,
    input  logic          next_n,
    input  logic          ld_bias,
    input  logic          ld_wt,
    output logic [AW-1:0] w_addr,
    output logic [IW-1:0] idx
);

    logic [AW-1:0] base;
    logic [AW-1:0] base_nx;
    logic [IW-1:0] idx_nx;

    always_comb begin
        base_nx = base;
        if (clr)
            base_nx = '0;
        else if (next_n)
            base_nx = base + AW'(STRIDE);
        idx_nx = idx;
        if (clr || next_n)
            idx_nx = '0;
        else if (step_i)
            idx_nx = idx + 1'b1;
    end

    // The address is loaded from the post-update counters so it lands together with the state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base   <= '0;
            idx    <= '0;
            w_addr <= '0;
        end else begin
            base <= base_nx;
            idx  <= idx_nx;
            if (ld_bias)
                w_addr <= base_nx + AW'(NI);
            else if (ld_wt)
                w_addr <= base_nx + AW'(idx_nx);
        end
    end

endmodule

// File: rtl/layer_sched.sv
// rtl/layer_sched.sv - dense-layer sequencer over a shared MAC and activation unit; NET_BIAS_EN adds the bias word
module layer_sched
    import net_pkg::*;
#(
    parameter int NI = 2,
    parameter int NO = 4,
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [32*NI-1:0] x,
    output logic [AW-1:0]   w_addr,
    input  logic [31:0]     w_data,
    output logic            mac_req,
    output logic [31:0]     mac_a,
    output logic [31:0]     mac_b,
    output logic [31:0]     mac_c,
    input  logic            mac_ack,
    input  logic [31:0]     mac_res,
    output logic            act_req,
    output logic [31:0]     act_in,
    input  logic            act_ack,
    input  logic [31:0]     act_out,
    output logic [32*NO-1:0] y,
    output logic            busy,
    output logic            done
);

`ifdef NET_BIAS_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif
    localparam int IW = cnt_w(NI);
    localparam int JW = cnt_w(NO);

    state_t          state;
    logic [31:0]     acc;
    logic [JW-1:0]   j;
    logic [32*NI-1:0] x_lat;
    logic [IW-1:0]   idx;
    logic            clr, step_i, next_n, ld_bias, ld_wt;
    logic            last_i, last_j;

    assign last_i = (idx == IW'(NI - 1));
    assign last_j = (j == JW'(NO - 1));

    // Weight data arrives a cycle after the address, so operand a is forwarded rather than registered.
    assign mac_a = mac_req ? w_data : FP_ZERO;

    always_comb begin
        clr     = 1'b0;
        step_i  = 1'b0;
        next_n  = 1'b0;
        ld_bias = 1'b0;
        ld_wt   = 1'b0;
        case (state)
            IDLE: if (start) begin
                clr     = 1'b1;
                ld_bias = (B == 1);
                ld_wt   = (B == 0);
            end
`ifdef NET_BIAS_EN
            BLD: ld_wt = 1'b1;
`endif
            MAC: if (mac_ack && !last_i) begin
                step_i = 1'b1;
                ld_wt  = 1'b1;
            end
            ACT: if (act_ack && !last_j) begin
                next_n  = 1'b1;
                ld_bias = (B == 1);
                ld_wt   = (B == 0);
            end
            default: ;
        endcase
    end

    wgt_addr_gen #(
        .NI    (NI),
        .AW    (AW),
        .STRIDE(NI + B),
        .IW    (IW)
    ) u_addr (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .step_i (step_i),
        .next_n (next_n),
        .ld_bias(ld_bias),
        .ld_wt  (ld_wt),
        .w_addr (w_addr),
        .idx    (idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= FP_ZERO;
            j       <= '0;
            x_lat   <= '0;
            mac_req <= 1'b0;
            mac_b   <= '0;
            mac_c   <= '0;
            act_req <= 1'b0;
            act_in  <= '0;
            y       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    x_lat <= x;
                    j     <= '0;
                    acc   <= FP_ZERO;
                    busy  <= 1'b1;
`ifdef NET_BIAS_EN
                    state <= BRD;
`else
                    state <= WRD;
`endif
                end
`ifdef NET_BIAS_EN
                BRD: state <= BLD;
                BLD: begin
                    acc   <= w_data;
                    state <= WRD;
                end
`endif
                WRD: begin
                    mac_req <= 1'b1;
                    mac_b   <= x_lat[32*idx +: 32];
                    mac_c   <= acc;
                    state   <= MAC;
                end
                MAC: if (mac_ack) begin
                    mac_req <= 1'b0;
                    acc     <= mac_res;
                    if (last_i) begin
                        act_req <= 1'b1;
                        act_in  <= mac_res;
                        state   <= ACT;
                    end else begin
                        state <= WRD;
                    end
                end
                ACT: if (act_ack) begin
                    act_req        <= 1'b0;
                    y[32*j +: 32]  <= act_out;
                    if (last_j) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        j     <= j + 1'b1;
                        acc   <= FP_ZERO;
`ifdef NET_BIAS_EN
                        state <= BRD;
`else
                        state <= WRD;
`endif
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sched.sv
// tb/tb_layer_sched.sv - scoreboard bench for layer_sched with behavioral fp MAC and activation stubs
module tb_layer_sched;
    import net_pkg::*;

    localparam int NI = 2;
    localparam int NO = 4;
    localparam int AW = 8;
`ifdef NET_BIAS_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif
    localparam int LAT = NO * (2*NI + 1 + 2*B);

    logic clk = 1'b0;
    logic rst, start;
    logic [32*NI-1:0] x;
    logic [AW-1:0] w_addr;
    logic [31:0] w_data;
    logic mac_req, mac_ack, act_req, act_ack, busy, done;
    logic [31:0] mac_a, mac_b, mac_c, mac_res, act_in, act_out;
    logic [32*NO-1:0] y;

    logic [31:0] mem [0:(1<<AW)-1];
    logic mac_ack_s = 1'b0, act_ack_s = 1'b0, stray_ack = 1'b0;
    int mac_dly = 0, act_dly = 0, act_mode = 0;
    int mcnt = 0, acnt = 0, hold_err = 0, excl_err = 0;
    logic [AW+95:0] hold;
    int cyc = 0, done_cnt = 0, n_chk = 0, n_pass = 0;
    logic log_en = 1'b0, was_busy = 1'b0;
    logic [AW-1:0] last_wa;
    int addr_log[$];
    int exp_addr[$];
    logic [32*NO-1:0] exp_y_q[$];
    int exp_cyc_q[$];

    assign mac_ack = mac_ack_s | stray_ack;
    assign act_ack = act_ack_s;

    layer_sched #(.NI(NI), .NO(NO), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x),
        .w_addr(w_addr), .w_data(w_data),
        .mac_req(mac_req), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
        .mac_ack(mac_ack), .mac_res(mac_res),
        .act_req(act_req), .act_in(act_in), .act_ack(act_ack), .act_out(act_out),
        .y(y), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_data <= mem[w_addr];
        cyc    <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic real f2r(input logic [31:0] b);
        int e;
        real r;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        r = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [23:0] mt;
        int e;
        if (r == 0.0) return FP_ZERO;
        d  = $realtobits(r);
        e  = int'(d[62:52]) - 1023 + 127;
        mt = {1'b0, d[51:29]};
        if (d[28] && ((|d[27:0]) || mt[0])) mt = mt + 24'd1;
        if (mt[23]) begin
            mt = '0;
            e  = e + 1;
        end
        return {d[63], 8'(e), mt[22:0]};
    endfunction

    function automatic logic [31:0] fmac(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return r2f(f2r(a) * f2r(b) + f2r(c));
    endfunction

    function automatic logic [31:0] act_fn(input logic [31:0] v);
        if (act_mode == 1) return r2f(1.0 / (1.0 + $exp(-f2r(v))));
        return v;
    endfunction

    function automatic logic [32*NO-1:0] model(input logic [32*NI-1:0] xv);
        logic [32*NO-1:0] r;
        logic [31:0] a;
        int base;
        r = '0;
        for (int jj = 0; jj < NO; jj++) begin
            base = jj * (NI + B);
            a = (B == 1) ? mem[base + NI] : FP_ZERO;
            for (int ii = 0; ii < NI; ii++)
                a = fmac(mem[base + ii], xv[32*ii +: 32], a);
            r[32*jj +: 32] = act_fn(a);
        end
        return r;
    endfunction

    // MAC and activation stubs: ack after a programmable number of wait cycles.
    always @(negedge clk) begin
        if (mac_req && act_req) excl_err++;
        if (!mac_req || mac_ack_s) begin
            mcnt      = 0;
            mac_ack_s = 1'b0;
        end else begin
            if (mcnt == 0) hold = {w_addr, mac_a, mac_b, mac_c};
            else if (hold !== {w_addr, mac_a, mac_b, mac_c}) hold_err++;
            if (mcnt == mac_dly) begin
                mac_ack_s = 1'b1;
                mac_res   = fmac(mac_a, mac_b, mac_c);
            end
            mcnt++;
        end
        if (!act_req || act_ack_s) begin
            acnt      = 0;
            act_ack_s = 1'b0;
        end else begin
            if (acnt == act_dly) begin
                act_ack_s = 1'b1;
                act_out   = act_fn(act_in);
            end
            acnt++;
        end
    end

    always @(negedge clk) begin
        if (log_en && busy && (!was_busy || w_addr != last_wa)) addr_log.push_back(int'(w_addr));
        last_wa  = w_addr;
        was_busy = busy;
        if (done) begin
            if (exp_y_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [32*NO-1:0] ey;
                int ec;
                ey = exp_y_q.pop_front();
                ec = exp_cyc_q.pop_front();
                for (int jj = 0; jj < NO; jj++)
                    chk($sformatf("y%0d", jj), 64'(y[32*jj +: 32]), 64'(ey[32*jj +: 32]));
                chk("done_cycle", 64'(cyc), 64'(ec));
            end
            done_cnt++;
        end
    end

    task automatic launch(input logic [32*NI-1:0] xv, input int extra);
        @(negedge clk);
        x     = xv;
        start = 1'b1;
        exp_y_q.push_back(model(xv));
        exp_cyc_q.push_back(cyc + 1 + LAT + extra);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = done_cnt;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done_cnt != n) return;
        end
        chk("done_timeout", 64'd1, 64'd0);
    endtask

    task automatic set_weights(input int kind);
        real wt [0:3][0:1] = '{'{20.0, 20.0}, '{-20.0, -20.0}, '{1.5, -1.5}, '{0.5, 0.75}};
        real bt [0:3] = '{-10.0, 30.0, 0.25, -1.0};
        for (int jj = 0; jj < NO; jj++) begin
            for (int ii = 0; ii < NI; ii++) begin
                if (kind == 0) mem[jj*(NI+B) + ii] = FP_ONE;
                else if (kind == 1) mem[jj*(NI+B) + ii] = r2f(real'((jj*NI + ii) % 7 - 3) * 0.25 + 0.125);
                else mem[jj*(NI+B) + ii] = r2f(wt[jj][ii]);
            end
            if (B == 1) begin
                if (kind == 0) mem[jj*(NI+B) + NI] = FP_ZERO;
                else if (kind == 1) mem[jj*(NI+B) + NI] = r2f(real'(jj) * 0.5 - 0.75);
                else mem[jj*(NI+B) + NI] = r2f(bt[jj]);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < (1<<AW); k++) mem[k] = FP_ZERO;
        rst = 1'b1; start = 1'b0; x = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 64'({busy, done, mac_req, act_req}), 64'd0);
        chk("reset_w_addr", 64'(w_addr), 64'd0);
        chk("reset_y", 64'(|y), 64'd0);
        rst = 1'b0;

        // all-ones weights, pass-through activation, address trace
        set_weights(0);
        act_mode = 0;
        addr_log.delete();
        log_en = 1'b1;
        launch({FP_ONE, FP_ONE}, 0);
        wait_done();
        log_en = 1'b0;
        chk("ones_y0", 64'(y[31:0]), 64'h40000000);
        exp_addr.delete();
        for (int jj = 0; jj < NO; jj++) begin
            if (B == 1) exp_addr.push_back(jj*(NI+1) + NI);
            for (int ii = 0; ii < NI; ii++) exp_addr.push_back(jj*(NI+B) + ii);
        end
        chk("addr_count", 64'(addr_log.size()), 64'(exp_addr.size()));
        for (int k = 0; k < exp_addr.size() && k < addr_log.size(); k++)
            chk($sformatf("addr%0d", k), 64'(addr_log[k]), 64'(exp_addr[k]));

        // varied weights, zero-wait then three-cycle MAC waits
        set_weights(1);
        launch({r2f(1.5), r2f(-0.75)}, 0);
        wait_done();
        mac_dly = 3;
        launch({r2f(-2.0), r2f(0.625)}, 3*NI*NO);
        wait_done();
        mac_dly = 0;
        chk("mac_hold", 64'(hold_err), 64'd0);

        // start re-pulsed and x changed mid-run, with slow activation
        act_dly = 2;
        launch({r2f(0.5), r2f(3.0)}, 2*NO);
        repeat (6) @(negedge clk);
        x = {r2f(7.0), r2f(-7.0)};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        act_dly = 0;
        repeat (10) @(negedge clk);
        chk("no_restart", 64'(busy), 64'd0);
        chk("queue_empty", 64'(exp_y_q.size()), 64'd0);

        // reset while waiting on the MAC, then a stray ack
        mac_dly = 3;
        launch({FP_ONE, r2f(2.0)}, 0);
        for (int k = 0; k < 100 && !mac_req; k++) @(negedge clk);
        chk("mac_req_seen", 64'(mac_req), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ctl", 64'({busy, done, mac_req, act_req}), 64'd0);
        chk("arst_w_addr", 64'(w_addr), 64'd0);
        chk("arst_mac_ab", {mac_a, mac_b}, 64'd0);
        chk("arst_mac_c_act", {mac_c, act_in}, 64'd0);
        chk("arst_y", 64'(|y), 64'd0);
        void'(exp_y_q.pop_back());
        void'(exp_cyc_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_ignored", 64'({busy, mac_req, act_req}), 64'd0);
        mac_dly = 0;
        launch({r2f(-1.25), r2f(0.5)}, 0);
        wait_done();

        // XOR hidden layer with sigmoid
        set_weights(2);
        act_mode = 1;
        for (int p = 0; p < 4; p++) begin
            launch({(p[1] ? FP_ONE : FP_ZERO), (p[0] ? FP_ONE : FP_ZERO)}, 0);
            wait_done();
        end

        chk("req_exclusive", 64'(excl_err), 64'd0);
        chk("mac_hold_final", 64'(hold_err), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/layer_sched.md
# layer_sched

Sequencer for one dense layer of the fp32 network. It computes y[j] = act(sum_i w[j][i]*x[i] + b[j]) for NO neurons. To do this it steps through NI inputs per neuron on a single shared floating-point multiply-accumulate unit and a single shared activation unit, both external. It fetches weights from a synchronous weight memory and sits between the `net` top-level control and the arithmetic datapath. One instance runs per layer, and the top chains them via start/done.

## Interface
Parameters:
- NI, 2: inputs per neuron (>=1)
- NO, 4: neurons (outputs) in the layer (>=1)
- AW, 8: weight-memory address width; NO*(NI+1) <= 2^AW

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  run request; sampled only in IDLE
- x  in  32*NI  input vector; x[32*i +: 32] is input i (IEEE-754 single)
- w_addr  out  AW  weight-memory read address (registered)
- w_data  in  32  weight-memory read data, valid the cycle after w_addr; stable while w_addr is stable
- mac_req  out  1  MAC operation request
- mac_a, mac_b, mac_c  out  32 each  operands; the MAC computes a*b+c
- mac_ack  in  1  one-cycle pulse; mac_res is valid in that cycle; may coincide with the first mac_req cycle
- mac_res  in  32  MAC result
- act_req  out  1  activation request
- act_in  out  32  activation operand
- act_ack  in  1  one-cycle pulse; act_out is valid in that cycle
- act_out  in  32  activation result
- y  out  32*NO  results; y[32*j +: 32] is neuron j, registered
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at run completion

## Operation
Per-neuron word layout in weight memory:
- B=1 with bias compiled in, B=0 without.
- Neuron j uses words base_j .. base_j+NI-1 for weights, and base_j+NI for the bias when B=1.
- base_j = j*(NI+B).

State sequence:
- IDLE: on start, latch x internally, set j=0 and base=0, then go to BRD (B=1) or WRD (B=0). x changes after the latch are ignored.
- BRD: w_addr=base+NI, then go to BLD.
- BLD: acc=w_data, i=0, then go to WRD.
- WRD: w_addr=base+i, then go to MAC.
- MAC: mac_req=1, mac_a=w_data, mac_b=x_lat[i], mac_c=acc. Hold all of them plus w_addr stable until mac_ack. On mac_ack: acc=mac_res. If i==NI-1 go to ACT, else i++ and go to WRD.
- ACT: act_req=1, act_in=acc, held until act_ack. On act_ack: y[j]=act_out. If j==NO-1 go to DONE. Otherwise j++, base+=NI+B, and go to BRD (B=1) or WRD with acc=0 and i=0 (B=0).
- DONE: done=1 for one cycle, then go to IDLE. y holds until the next run overwrites it neuron by neuron.

Handshake and edge rules:
- mac_ack and act_ack are ignored in any state other than MAC and ACT respectively.
- start is ignored while busy.
- No arithmetic is performed locally; acc is a 32-bit register, and i and j counters are $clog2 sized (min 1 bit).

Reset, asynchronous: state=IDLE, and w_addr, mac_req, mac_a/b/c, act_req, act_in, y, busy, done all clear to 0 immediately. Reset mid-run discards the operation; late acks arriving afterwards are ignored.

## Timing
- With zero-wait acks (ack in the first request cycle), one neuron takes 2*NI+1+2B cycles.
- done is high in the cycle after edge N = NO*(2*NI+1+2B) counted from the start-sampling edge.
  - NI=2, NO=4, B=1: N=28.
- Each extra wait cycle on mac_ack or act_ack adds exactly one cycle.
- mac_req and act_req are never both high.
- w_addr is never changed while mac_req=1.

## Configuration
- NET_BIAS_EN defined: B=1. The accumulator is seeded from the bias word, the BRD and BLD states exist, and the stride is NI+1.
- NET_BIAS_EN undefined: B=0. The accumulator is seeded with +0.0 (32'h00000000), BRD and BLD are removed, and the stride is NI.

## Structure
- Shared package `net_pkg` holds:
  - FP_ZERO=32'h00000000 and FP_ONE=32'h3f800000
  - the state encoding (IDLE, BRD, BLD, WRD, MAC, ACT, DONE)
- One sub-module, `wgt_addr_gen`, holds the base/i counters and produces w_addr incrementally (base += stride), so no multiplier is needed.

## Test plan
Bench uses behavioral fp MAC and activation stubs with configurable ack delay.
- NI=2, NO=1, NET_BIAS_EN, weights {1.0,1.0}, bias 0, pass-through act, x={FP_ONE,FP_ONE} -> y=32'h40000000, done one cycle after edge 7.
- NI=2, NO=2, NET_BIAS_EN -> w_addr sequence 2,0,1,5,3,4. Without the macro -> 0,1,2,3, done after edge 10 (NO*(2*NI+1)=2*5).
- mac_ack delayed 3 cycles on every term -> mac_req/a/b/c/w_addr stay constant while waiting, y is unchanged, done is later by 3*NI*NO cycles.
- start pulsed and x altered mid-run -> no restart, y computed from the x latched at start.
- rst asserted during MAC, then a stray mac_ack -> all outputs 0 immediately, ack ignored. A following start completes normally with correct y.
- XOR hidden layer (NI=2, NO=4, sigmoid stub) across inputs {0,0},{0,1},{1,0},{1,1} -> y matches the reference model bit-exactly, done after edge 28.
